// File: rtl/rep_code_serial_tx_pkg.sv
// Shared definitions for the repetition-code serial link: frame states, line
// levels and counter sizing, also used by the matching majority-vote receiver.
package rep_code_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

  // Bits needed to count 0..range_n-1, never less than one.
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/rep_code_serial_tx_timer.sv
// Chip timer: counts CHIP_CLKS cycles per chip, synchronous clear, tick on the
// wrap cycle plus a look-ahead flag saying whether the next cycle will wrap.
module rep_chip_timer
  import rep_code_serial_tx_pkg::*;
#(
  parameter int CHIP_CLKS = 4
) (
  input  logic clk,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int TW = cnt_width(CHIP_CLKS);
  localparam logic [TW-1:0] LAST     = TW'(CHIP_CLKS - 1);
  localparam logic [TW-1:0] PRE_LAST = TW'((CHIP_CLKS > 1) ? CHIP_CLKS - 2 : 0);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  assign tick = (count == LAST);

  // A cleared or wrapping timer restarts at zero, which only wraps again at once for one-cycle chips.
  assign tick_next = (CHIP_CLKS == 1) ? 1'b1 : (!clear && count == PRE_LAST);

endmodule

// File: rtl/rep_code_serial_tx.sv
// Repetition-code serial transmitter: frames a word as start, LSB-first data,
// stop, each bit sent as REP chips of CHIP_CLKS cycles; line idles high.
module rep_code_serial_tx
  import rep_code_serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REP       = 3,
  parameter int CHIP_CLKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int RW = cnt_width(REP);
  localparam int BW = cnt_width(DATA_W);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  tx_state_e         state, state_nxt;
  logic [RW-1:0]     rep_cnt, rep_nxt;
  logic [BW-1:0]     bit_idx, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              line_nxt, done_nxt;
  logic              chip_tick, chip_tick_next, timer_clear, accept;

  assign accept      = din_valid && din_ready;
  assign timer_clear = rst || (state == ST_IDLE);

  rep_chip_timer #(
    .CHIP_CLKS(CHIP_CLKS)
  ) u_chip_timer (
    .clk      (clk),
    .clear    (timer_clear),
    .tick     (chip_tick),
    .tick_next(chip_tick_next)
  );

  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_START;
          shreg_nxt = din;
          rep_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      default: begin
        if (chip_tick) begin
          if (rep_cnt == REP_LAST) begin
            rep_nxt = '0;
            case (state)
              ST_START: begin
                state_nxt = ST_DATA;
                bit_nxt   = '0;
              end
              ST_DATA: begin
                if (bit_idx == BIT_LAST) begin
                  state_nxt = ST_STOP;
                end else begin
                  bit_nxt   = bit_idx + BW'(1);
                  shreg_nxt = shreg >> 1;
                end
              end
              ST_STOP: begin
                state_nxt = ST_IDLE;
                bit_nxt   = '0;
              end
              default: ;
            endcase
          end else begin
            rep_nxt = rep_cnt + RW'(1);
          end
        end
      end
    endcase
  end

  // Outputs are registered, so they are derived from where the FSM is going next.
  always_comb begin
    case (state_nxt)
      ST_START: line_nxt = START_LEVEL;
      ST_DATA:  line_nxt = shreg_nxt[0];
      ST_STOP:  line_nxt = STOP_LEVEL;
      default:  line_nxt = LINE_IDLE_LEVEL;
    endcase
    done_nxt = (state_nxt == ST_STOP) && (rep_nxt == REP_LAST) && chip_tick_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rep_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx_out     <= LINE_IDLE_LEVEL;
      busy       <= 1'b0;
      din_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      rep_cnt    <= rep_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx_out     <= line_nxt;
      busy       <= (state_nxt != ST_IDLE);
      din_ready  <= (state_nxt == ST_IDLE);
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rep_code_serial_tx.sv
// Scoreboard bench for rep_code_serial_tx: accepted words are queued, a monitor
// captures each frame off the line and checks it against a chip-level model.
module tb_rep_code_serial_tx;

  localparam int DW    = 8;
  localparam int REP_A = 3;
  localparam int CLK_A = 2;
  localparam int REP_B = 5;
  localparam int CLK_B = 1;
  localparam int N_A   = (DW + 2) * REP_A * CLK_A;
  localparam int N_B   = (DW + 2) * REP_B * CLK_B;

  typedef struct {
    logic [DW-1:0] word;
    int            abort_len;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] a_din = '0;
  logic          a_valid = 1'b0;
  logic          a_ready, a_tx, a_busy, a_done;
  logic [DW-1:0] b_din = '0;
  logic          b_valid = 1'b0;
  logic          b_ready, b_tx, b_busy, b_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  rep_code_serial_tx #(.DATA_W(DW), .REP(REP_A), .CHIP_CLKS(CLK_A)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .tx_out(a_tx), .busy(a_busy), .frame_done(a_done)
  );

  rep_code_serial_tx #(.DATA_W(DW), .REP(REP_B), .CHIP_CLKS(CLK_B)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .tx_out(b_tx), .busy(b_busy), .frame_done(b_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Line level expected at cycle idx of a frame: bit slot 0 is start, then data LSB first, then stop.
  function automatic bit exp_level(input logic [31:0] w, input int dw, input int rep,
                                   input int clks, input int idx);
    int slot;
    slot = idx / (rep * clks);
    if (slot == 0) return 1'b0;
    if (slot > dw) return 1'b1;
    return w[slot-1];
  endfunction

  // What a far-end receiver recovers: mid-chip samples, strict majority per bit.
  function automatic logic [31:0] vote_decode(input logic s[$], input int dw, input int rep,
                                              input int clks);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < dw; b++) begin
      int ones;
      ones = 0;
      for (int r = 0; r < rep; r++) begin
        int idx;
        idx = (b + 1) * rep * clks + r * clks + clks / 2;
        if (idx < s.size() && s[idx] === 1'b1) ones++;
      end
      w[b] = (ones > rep / 2);
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w, input int abort_len, output int acc_cyc);
    int guard;
    guard = 0;
    a_din   = w;
    a_valid = 1'b1;
    while (a_ready !== 1'b1 && guard < 4 * N_A) begin
      @(negedge clk);
      guard++;
    end
    if (a_ready !== 1'b1) begin
      failNow("accept_timeout");
      a_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    exp_q.push_back('{word: w, abort_len: abort_len});
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (a_busy !== 1'b0 && guard < 4 * N_A) begin
      @(negedge clk);
      guard++;
    end
    if (a_busy !== 1'b0) failNow("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  logic samples[$];
  int   done_cnt = 0;
  int   done_pos = 0;

  task automatic finishFrame();
    exp_t e;
    int   mism;
    int   len;
    mism = 0;
    len  = samples.size();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_frame: got a %0d-cycle frame, expected none", len);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < len && i < N_A; i++)
      if (samples[i] !== exp_level(32'(e.word), DW, REP_A, CLK_A, i)) mism++;
    if (e.abort_len > 0) begin
      checkOutput("abort_len", len, e.abort_len);
      checkOutput("abort_no_done", done_cnt, 0);
      checkOutput("abort_prefix_mism", mism, 0);
    end else begin
      checkOutput("frame_len", len, N_A);
      checkOutput("done_count", done_cnt, 1);
      checkOutput("done_pos", done_pos, N_A);
      checkOutput("waveform_mism", mism, 0);
      checkOutput("decoded_word", vote_decode(samples, DW, REP_A, CLK_A), 32'(e.word));
    end
  endtask

  // Monitor: a frame is the run of busy cycles; judge it when busy drops.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_busy === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          samples.delete();
          done_cnt = 0;
          done_pos = 0;
        end
        samples.push_back(a_tx);
        if (a_done === 1'b1) begin
          done_cnt++;
          done_pos = samples.size();
        end
        checkOutput("ready_low_in_frame", a_ready, 0);
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          finishFrame();
        end
        checkOutput("idle_tx", a_tx, 1);
        checkOutput("idle_ready", a_ready, 1);
        checkOutput("idle_done", a_done, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            t1, t2, mism;
    logic [DW-1:0] w;
    bit            hold;
    logic          bsamp[$];

    // Reset held three cycles, then idle with no valid.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) begin
      checkOutput("rst_busy", a_busy, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_busy", a_busy, 0);
      checkOutput("idle_tx_after_rst", a_tx, 1);
    end

    applyStimulus(8'hA5, 0, t1);
    a_valid = 1'b0;
    waitIdle();

    // Valid held high across two words.
    applyStimulus(8'h3C, 0, t1);
    applyStimulus(8'hC3, 0, t2);
    a_valid = 1'b0;
    checkOutput("b2b_accept_spacing", t2 - t1, N_A + 1);
    waitIdle();

    // Noise on din/din_valid while the frame is in flight.
    applyStimulus(8'h5A, 0, t1);
    for (int i = 0; i < N_A - 6; i++) begin
      a_din   = DW'($urandom);
      a_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    a_valid = 1'b0;
    waitIdle();

    // Reset during busy cycle 20 abandons the frame.
    w = DW'($urandom);
    applyStimulus(w, 20, t1);
    a_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", a_busy, 0);
    checkOutput("abort_tx", a_tx, 1);
    checkOutput("abort_done", a_done, 0);
    waitIdle();
    applyStimulus(DW'($urandom), 0, t1);
    a_valid = 1'b0;
    waitIdle();

    // Reset and a would-be accept on the same edge.
    a_din   = 8'h77;
    a_valid = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    checkOutput("rst_wins_busy", a_busy, 0);
    @(negedge clk);
    checkOutput("rst_wins_busy_later", a_busy, 0);

    for (int k = 0; k < 8; k++) begin
      hold = 1'($urandom_range(0, 1));
      applyStimulus(DW'($urandom), 0, t1);
      if (!hold || k == 7) begin
        a_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    a_valid = 1'b0;
    waitIdle();
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    // Second instance: five chips of one cycle each.
    b_din   = 8'h01;
    b_valid = 1'b1;
    checkOutput("b_ready_idle", b_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    mism = 0;
    for (int i = 0; i < N_B; i++) begin
      bsamp.push_back(b_tx);
      if (b_busy !== 1'b1) mism++;
      if (b_done !== ((i == N_B - 1) ? 1'b1 : 1'b0)) mism++;
      @(negedge clk);
    end
    checkOutput("b_busy_done_mism", mism, 0);
    checkOutput("b_end_busy", b_busy, 0);
    mism = 0;
    foreach (bsamp[i])
      if (bsamp[i] !== exp_level(32'h01, DW, REP_B, CLK_B, i)) mism++;
    checkOutput("b_waveform_mism", mism, 0);
    checkOutput("b_decoded_word", vote_decode(bsamp, DW, REP_B, CLK_B), 32'h01);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
